// File: rtl/checker_pkg.sv
// Shared definitions for the result checker.
// - state_e:   checker FSM states, encoded as they appear on the state output
// - FB_*:      bit positions inside fail_mask / first_fail_mask
// - NUM_CHECKS: number of independent output comparisons per cycle
package checker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2,
        HALT   = 2'd3
    } state_e;

    localparam int NUM_CHECKS = 5;

    localparam int FB_IP  = 0;  // immediate_plus  == a + b
    localparam int FB_IM  = 1;  // immediate_minus == a - b
    localparam int FB_DPI = 2;  // dpi_plus        == a + b
    localparam int FB_CP  = 3;  // clocked_plus    == a_prev + b_prev
    localparam int FB_CNT = 4;  // counter         == cnt_prev + 1

endpackage

// File: rtl/sat_counter.sv
// Up-counter with optional saturation.
// Ports:
//   clk     clock
//   rst     synchronous active-high reset (count -> 0)
//   clr     synchronous soft clear (count -> 0)
//   inc     advance the count by one this cycle
//   sat_en  1: hold at all-ones instead of wrapping; 0: wrap to zero
//   count   current count
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             sat_en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;
    logic             at_max;

    assign at_max = &count_reg;
    assign count  = count_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (inc && !(sat_en && at_max)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/result_checker.sv
// Self-checking stage placed behind the arithmetic demo top. Every enabled
// cycle it recomputes what each top output should be from the sampled
// operands (and the operands/counter of the previous enabled cycle), flags
// mismatches, counts checks and failing cycles, and captures the first
// failure. With STOP_ON_FAIL=1 the checker freezes in HALT on that failure.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   en               sample and check this cycle
//   clear            synchronous soft clear (same effect as rst)
//   a, b             operands driven into the top
//   counter, immediate_plus, immediate_minus, clocked_plus, dpi_plus
//                    top outputs under check
//   state            IDLE=0, WARMUP=1, RUN=2, HALT=3
//   check_count      enabled cycles in which checks were evaluated (wraps)
//   error_count      cycles with at least one mismatch (saturates)
//   fail_mask        mismatches of the last sampled cycle
//   first_fail_mask  fail_mask of the first failing cycle
//   first_fail_idx   check_count value at the first failure
//   sticky_err       set on first mismatch, held until rst/clear
module result_checker
    import checker_pkg::*;
#(
    parameter int W            = 16,
    parameter int CNT_W        = 32,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clear,
    input  logic [W-1:0]          a,
    input  logic [W-1:0]          b,
    input  logic [W-1:0]          counter,
    input  logic [W-1:0]          immediate_plus,
    input  logic [W-1:0]          immediate_minus,
    input  logic [W-1:0]          clocked_plus,
    input  logic [W-1:0]          dpi_plus,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      check_count,
    output logic [CNT_W-1:0]      error_count,
    output logic [NUM_CHECKS-1:0] fail_mask,
    output logic [NUM_CHECKS-1:0] first_fail_mask,
    output logic [CNT_W-1:0]      first_fail_idx,
    output logic                  sticky_err
);

    state_e                  state_reg, state_next;
    logic [W-1:0]            a_prev_reg, b_prev_reg, cnt_prev_reg;
    logic [NUM_CHECKS-1:0]   fail_mask_reg, fail_mask_next;
    logic [NUM_CHECKS-1:0]   first_fail_mask_reg;
    logic [CNT_W-1:0]        first_fail_idx_reg;
    logic                    sticky_reg;

    logic [NUM_CHECKS-1:0][W-1:0] expected_v;
    logic [NUM_CHECKS-1:0][W-1:0] observed_v;
    logic [NUM_CHECKS-1:0]        raw_fail;
    logic [NUM_CHECKS-1:0]        check_enable;
    logic                         checking;      // enabled WARMUP/RUN cycle
    logic                         capture_prev;
    logic                         any_fail;
    logic [CNT_W-1:0]             check_count_w;
    logic [CNT_W-1:0]             error_count_w;

    // Expected values, all modulo 2^W by truncation to W bits.
    assign expected_v[FB_IP]  = a + b;
    assign expected_v[FB_IM]  = a - b;
    assign expected_v[FB_DPI] = a + b;
    assign expected_v[FB_CP]  = a_prev_reg + b_prev_reg;
    assign expected_v[FB_CNT] = cnt_prev_reg + 1'b1;  // 0xFFFF -> 0 is a pass

    assign observed_v[FB_IP]  = immediate_plus;
    assign observed_v[FB_IM]  = immediate_minus;
    assign observed_v[FB_DPI] = dpi_plus;
    assign observed_v[FB_CP]  = clocked_plus;
    assign observed_v[FB_CNT] = counter;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHECKS; gi++) begin : g_cmp
            assign raw_fail[gi] = (expected_v[gi] != observed_v[gi]);
        end
    endgenerate

    assign any_fail = |fail_mask_next;

    always_comb begin
        state_next     = state_reg;
        fail_mask_next = '0;
        check_enable   = '1;
        checking       = 1'b0;
        capture_prev   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (en) begin
                    state_next   = WARMUP;
                    capture_prev = 1'b1;
                end
            end
            WARMUP, RUN: begin
                // The previous-sample registers only hold a real sample from
                // the second enabled cycle on, so the registered-sum and
                // counter checks are skipped during WARMUP.
                if (state_reg == WARMUP) begin
                    check_enable[FB_CP]  = 1'b0;
                    check_enable[FB_CNT] = 1'b0;
                end
                if (en) begin
                    checking       = 1'b1;
                    capture_prev   = 1'b1;
                    fail_mask_next = raw_fail & check_enable;
                    if ((|(raw_fail & check_enable)) && (STOP_ON_FAIL != 0)) begin
                        state_next = HALT;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_reg           <= IDLE;
            a_prev_reg          <= '0;
            b_prev_reg          <= '0;
            cnt_prev_reg        <= '0;
            fail_mask_reg       <= '0;
            first_fail_mask_reg <= '0;
            first_fail_idx_reg  <= '0;
            sticky_reg          <= 1'b0;
        end else begin
            state_reg     <= state_next;
            fail_mask_reg <= fail_mask_next;
            if (capture_prev) begin
                a_prev_reg   <= a;
                b_prev_reg   <= b;
                cnt_prev_reg <= counter;
            end
            // First-failure capture uses the count before this cycle's increment.
            if (checking && any_fail && !sticky_reg) begin
                sticky_reg          <= 1'b1;
                first_fail_mask_reg <= fail_mask_next;
                first_fail_idx_reg  <= check_count_w;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_check_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (clear),
        .inc    (checking),
        .sat_en (1'b0),
        .count  (check_count_w)
    );

    sat_counter #(.CNT_W(CNT_W)) u_error_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (clear),
        .inc    (checking && any_fail),
        .sat_en (1'b1),
        .count  (error_count_w)
    );

    assign state           = state_reg;
    assign check_count     = check_count_w;
    assign error_count     = error_count_w;
    assign fail_mask       = fail_mask_reg;
    assign first_fail_mask = first_fail_mask_reg;
    assign first_fail_idx  = first_fail_idx_reg;
    assign sticky_err      = sticky_reg;

endmodule

// File: tb/tb_result_checker.sv
// Bench for result_checker. Three checkers watch the same stimulus:
//   0: STOP_ON_FAIL=1, 32-bit counters
//   1: STOP_ON_FAIL=0, 32-bit counters
//   2: STOP_ON_FAIL=0, 3-bit counters (exercises saturation and wrap)
// A small model of the demo top (counter and registered sum advance on
// enabled cycles) drives the checked outputs, with injectable corruptions.
module tb_result_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;

    // Corruption controls.
    logic ip_bad = 1'b0, cp_bad = 1'b0, cnt_bad = 1'b0, dpi_force = 1'b0;

    // Demo-top model.
    logic [15:0] t_cnt, t_cp, sum_ab, dif_ab;
    logic [15:0] counter, immediate_plus, immediate_minus, clocked_plus, dpi_plus;

    assign sum_ab          = a_in + b_in;
    assign dif_ab          = a_in - b_in;
    assign immediate_plus  = sum_ab ^ (ip_bad ? 16'h0001 : 16'h0000);
    assign immediate_minus = dif_ab;
    assign dpi_plus        = dpi_force ? 16'h1234 : sum_ab;
    assign clocked_plus    = t_cp ^ (cp_bad ? 16'h0100 : 16'h0000);
    assign counter         = t_cnt ^ (cnt_bad ? 16'h0002 : 16'h0000);

    always #5 clk = ~clk;

    // Counter starts near the top so the wrap is reached quickly.
    always @(posedge clk) begin
        if (rst) begin
            t_cnt <= 16'hFFF8;
            t_cp  <= 16'h0000;
        end else if (en) begin
            t_cnt <= t_cnt + 16'd1;
            t_cp  <= sum_ab;
        end
    end

    // DUT outputs gathered per instance.
    logic [1:0]  st  [3];
    logic [31:0] cc  [3];
    logic [31:0] ec  [3];
    logic [31:0] fi  [3];
    logic [4:0]  fm  [3];
    logic [4:0]  ffm [3];
    logic        sk  [3];
    logic [2:0]  cc_s, ec_s, fi_s;
    logic [31:0] cc0, ec0, fi0, cc1, ec1, fi1;

    assign cc[0] = cc0; assign ec[0] = ec0; assign fi[0] = fi0;
    assign cc[1] = cc1; assign ec[1] = ec1; assign fi[1] = fi1;
    assign cc[2] = {29'd0, cc_s};
    assign ec[2] = {29'd0, ec_s};
    assign fi[2] = {29'd0, fi_s};

    result_checker #(.W(16), .CNT_W(32), .STOP_ON_FAIL(1)) dut_stop (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .a(a_in), .b(b_in),
        .counter(counter), .immediate_plus(immediate_plus),
        .immediate_minus(immediate_minus), .clocked_plus(clocked_plus),
        .dpi_plus(dpi_plus), .state(st[0]), .check_count(cc0),
        .error_count(ec0), .fail_mask(fm[0]), .first_fail_mask(ffm[0]),
        .first_fail_idx(fi0), .sticky_err(sk[0])
    );

    result_checker #(.W(16), .CNT_W(32), .STOP_ON_FAIL(0)) dut_run (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .a(a_in), .b(b_in),
        .counter(counter), .immediate_plus(immediate_plus),
        .immediate_minus(immediate_minus), .clocked_plus(clocked_plus),
        .dpi_plus(dpi_plus), .state(st[1]), .check_count(cc1),
        .error_count(ec1), .fail_mask(fm[1]), .first_fail_mask(ffm[1]),
        .first_fail_idx(fi1), .sticky_err(sk[1])
    );

    result_checker #(.W(16), .CNT_W(3), .STOP_ON_FAIL(0)) dut_small (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .a(a_in), .b(b_in),
        .counter(counter), .immediate_plus(immediate_plus),
        .immediate_minus(immediate_minus), .clocked_plus(clocked_plus),
        .dpi_plus(dpi_plus), .state(st[2]), .check_count(cc_s),
        .error_count(ec_s), .fail_mask(fm[2]), .first_fail_mask(ffm[2]),
        .first_fail_idx(fi_s), .sticky_err(sk[2])
    );

    // ---------------- behavioural model of the checker ----------------
    int          cw    [3] = '{32, 32, 3};
    bit          stopf [3] = '{1'b1, 1'b0, 1'b0};
    int          m_state  [3];
    longint      m_chk    [3];
    longint      m_err    [3];
    longint      m_ffi    [3];
    logic [4:0]  m_fail   [3];
    logic [4:0]  m_ffm    [3];
    bit          m_sticky [3];
    logic [15:0] m_ap [3];
    logic [15:0] m_bp [3];
    logic [15:0] m_cn [3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            longint      mx;
            logic [4:0]  f;
            logic [15:0] psum, nxt;
            mx = longint'((64'd1 << cw[k]) - 64'd1);
            if (rst || clear) begin
                m_state[k] = 0; m_chk[k] = 0; m_err[k] = 0; m_ffi[k] = 0;
                m_fail[k] = '0; m_ffm[k] = '0; m_sticky[k] = 1'b0;
                m_ap[k] = '0; m_bp[k] = '0; m_cn[k] = '0;
            end else if (en && (m_state[k] == 1 || m_state[k] == 2)) begin
                f    = '0;
                f[0] = (immediate_plus  != sum_ab);
                f[1] = (immediate_minus != dif_ab);
                f[2] = (dpi_plus        != sum_ab);
                if (m_state[k] == 2) begin
                    psum = m_ap[k] + m_bp[k];
                    nxt  = m_cn[k] + 16'd1;
                    f[3] = (clocked_plus != psum);
                    f[4] = (counter != nxt);
                end
                m_fail[k] = f;
                if (f != 5'd0) begin
                    if (!m_sticky[k]) begin
                        m_sticky[k] = 1'b1;
                        m_ffm[k]    = f;
                        m_ffi[k]    = m_chk[k];
                    end
                    if (m_err[k] < mx) m_err[k] = m_err[k] + 1;
                end
                m_chk[k] = (m_chk[k] + 1) & mx;
                m_ap[k] = a_in; m_bp[k] = b_in; m_cn[k] = counter;
                m_state[k] = (f != 5'd0 && stopf[k]) ? 3 : 2;
            end else begin
                m_fail[k] = '0;
                if (en && m_state[k] == 0) begin
                    m_ap[k] = a_in; m_bp[k] = b_in; m_cn[k] = counter;
                    m_state[k] = 1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("m%0d state", k),           64'(st[k]),  64'(m_state[k]));
            chk($sformatf("m%0d check_count", k),     64'(cc[k]),  64'(m_chk[k]));
            chk($sformatf("m%0d error_count", k),     64'(ec[k]),  64'(m_err[k]));
            chk($sformatf("m%0d fail_mask", k),       64'(fm[k]),  64'(m_fail[k]));
            chk($sformatf("m%0d first_fail_mask", k), 64'(ffm[k]), 64'(m_ffm[k]));
            chk($sformatf("m%0d first_fail_idx", k),  64'(fi[k]),  64'(m_ffi[k]));
            chk($sformatf("m%0d sticky_err", k),      64'(sk[k]),  64'(m_sticky[k]));
        end
    end

    int step_no = 0;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            step_no++;
            $display("step %0d: rst=%0b clr=%0b en=%0b a=%h b=%h cnt=%h | st=%0d/%0d/%0d cc=%0d/%0d/%0d ec=%0d/%0d/%0d fm=%b/%b/%b",
                     step_no, rst, clear, en, a_in, b_in, counter,
                     st[0], st[1], st[2], cc[0], cc[1], cc[2],
                     ec[0], ec[1], ec[2], fm[0], fm[1], fm[2]);
        end
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        tick(2);
        chk("reset state", 64'(st[0]), 64'd0);
        chk("reset check_count", 64'(cc[0]), 64'd0);
        chk("reset sticky", 64'(sk[1]), 64'd0);

        // Warm-up and steady run with a correct top.
        rst = 1'b0; en = 1'b1; a_in = 16'd3; b_in = 16'd5;
        tick(1);
        chk("warmup entered", 64'(st[0]), 64'd1);
        tick(3);
        chk("run state", 64'(st[0]), 64'd2);
        chk("run check_count", 64'(cc[0]), 64'd3);
        chk("run error_count", 64'(ec[0]), 64'd0);
        chk("run sticky", 64'(sk[0]), 64'd0);

        // Wrap cases: a+b -> 0, counter FFFF -> 0.
        a_in = 16'hFFFF; b_in = 16'h0001;
        tick(5);
        chk("wrap counter value", 64'(counter), 64'd1);
        chk("wrap fail_mask", 64'(fm[0]), 64'd0);
        chk("wrap check_count", 64'(cc[0]), 64'd8);
        chk("wrap error_count", 64'(ec[1]), 64'd0);

        // DPI corruption: halts the stopping checker.
        a_in = 16'd1; b_in = 16'd1; dpi_force = 1'b1;
        tick(1);
        chk("dpi fail_mask", 64'(fm[0]), 64'h04);
        chk("dpi sticky", 64'(sk[0]), 64'd1);
        chk("dpi first_fail_mask", 64'(ffm[0]), 64'h04);
        chk("dpi first_fail_idx", 64'(fi[0]), 64'd8);
        chk("dpi halt", 64'(st[0]), 64'd3);
        chk("dpi nonstop state", 64'(st[1]), 64'd2);
        dpi_force = 1'b0;
        tick(1);
        chk("halt frozen count", 64'(cc[0]), 64'd9);
        chk("halt fail_mask", 64'(fm[0]), 64'd0);
        chk("nonstop count", 64'(cc[1]), 64'd10);

        // Soft clear from HALT.
        clear = 1'b1;
        tick(1);
        chk("clear state", 64'(st[0]), 64'd0);
        chk("clear error_count", 64'(ec[0]), 64'd0);
        chk("clear first_fail_idx", 64'(fi[1]), 64'd0);
        clear = 1'b0; a_in = 16'd2; b_in = 16'd3;
        tick(1);
        cp_bad = 1'b1;
        tick(1);
        chk("warmup masks cp", 64'(fm[1]), 64'd0);
        chk("warmup to run", 64'(st[1]), 64'd2);
        chk("warmup count", 64'(cc[1]), 64'd1);

        // Registered-sum corruption on 3 cycles, counter on the last of them.
        tick(2);
        cnt_bad = 1'b1;
        tick(1);
        chk("cp+cnt fail_mask", 64'(fm[1]), 64'h18);
        cp_bad = 1'b0; cnt_bad = 1'b0;
        tick(1);
        chk("cnt fallout mask", 64'(fm[1]), 64'h10);
        chk("nonstop error_count", 64'(ec[1]), 64'd4);
        chk("first mask holds", 64'(ffm[1]), 64'h08);
        chk("first idx holds", 64'(fi[1]), 64'd1);
        chk("nonstop stays run", 64'(st[1]), 64'd2);
        chk("stop halted on cp", 64'(st[0]), 64'd3);
        chk("stop error_count", 64'(ec[0]), 64'd1);
        tick(1);
        chk("clean after fallout", 64'(fm[1]), 64'd0);

        // Enable gap with stable operands.
        en = 1'b0;
        tick(5);
        chk("gap count held", 64'(cc[1]), 64'd6);
        chk("gap fail_mask", 64'(fm[1]), 64'd0);
        en = 1'b1;
        tick(2);
        chk("resume count", 64'(cc[1]), 64'd8);
        chk("resume no cnt fail", 64'(fm[1]), 64'd0);
        chk("resume error_count", 64'(ec[1]), 64'd4);

        // Error burst: saturates the narrow counters.
        ip_bad = 1'b1;
        tick(4);
        ip_bad = 1'b0;
        chk("burst error_count", 64'(ec[1]), 64'd8);
        chk("small error saturated", 64'(ec[2]), 64'd7);
        chk("small check wrapped", 64'(cc[2]), 64'd4);

        // Hard reset mid-run, then warm-up again.
        rst = 1'b1; en = 1'b0;
        tick(1);
        chk("rst state", 64'(st[1]), 64'd0);
        chk("rst check_count", 64'(cc[1]), 64'd0);
        chk("rst sticky", 64'(sk[1]), 64'd0);
        rst = 1'b0; en = 1'b1;
        tick(1);
        chk("rerun warmup", 64'(st[1]), 64'd1);
        cp_bad = 1'b1; cnt_bad = 1'b0;
        tick(1);
        chk("rerun masked", 64'(fm[1]), 64'd0);
        chk("rerun count", 64'(cc[1]), 64'd1);
        cp_bad = 1'b0;
        tick(2);
        chk("rerun clean", 64'(fm[1]), 64'd0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
